// File: rtl/cu_vertex_cache_assoc_module.sv
// Direct-mapped vertex-data cache for the PageRank CSR pull CU: hits are answered locally,
// misses are forwarded, fills come from the vertex-data return path.
module cu_vertex_cache_assoc_module #(
    parameter int ENTRIES    = 4096,
    parameter int ADDR_BITS  = 32,
    parameter int DATA_BITS  = 32,
    parameter int ID_BITS    = 8,
    parameter int LANES      = 16,
    parameter int INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic                       clock,
    input  logic                       rst_in,
    input  logic                       enabled_in,
    input  logic                       flush_in,
    input  logic                       req_valid_in,
    input  logic [ADDR_BITS-1:0]       req_addr_in,
    input  logic [ID_BITS-1:0]         req_id_in,
    input  logic                       fill_valid_in,
    input  logic [ADDR_BITS-1:0]       fill_addr_in,
    input  logic [DATA_BITS-1:0]       fill_data_in,
    output logic                       rsp_valid_out,
    output logic [ID_BITS-1:0]         rsp_id_out,
    output logic [DATA_BITS*LANES-1:0] rsp_data_out,
    output logic                       miss_valid_out,
    output logic [ADDR_BITS-1:0]       miss_addr_out,
    output logic [ID_BITS-1:0]         miss_id_out,
    output logic                       busy_out,
    output logic                       flush_done_out,
    output logic [31:0]                hit_count_out,
    output logic [31:0]                miss_count_out
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(ENTRIES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_BITS-1:0]  tag;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // Flush/init state machine
    // ------------------------------------------------------------------
    state_t                state_q;
    logic [INDEX_BITS-1:0] sweep_q;
    logic                  busy_q;
    logic                  done_q;

    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (rst_in) begin
            state_q <= ST_FLUSH;
            sweep_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (flush_in) begin
                        state_q <= ST_FLUSH;
                        sweep_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_in) begin
                        sweep_q <= '0;
                    end else if (sweep_q == LAST_INDEX) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        sweep_q <= sweep_q + INDEX_BITS'(1);
                    end
                end
                default: begin
                    state_q <= ST_FLUSH;
                    sweep_q <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fill capture: a fill commits one cycle after it is sampled
    // ------------------------------------------------------------------
    logic                 fill_valid_q;
    logic [ADDR_BITS-1:0] fill_addr_q;
    logic [DATA_BITS-1:0] fill_data_q;

    always_ff @(posedge clock) begin
        if (rst_in) begin
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
        end else begin
            fill_valid_q <= fill_valid_in && enabled_in && (state_q == ST_IDLE);
            fill_addr_q  <= fill_addr_in;
            fill_data_q  <= fill_data_in;
        end
    end

    // ------------------------------------------------------------------
    // Single write port: the sweep owns it while flushing
    // ------------------------------------------------------------------
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    entry_t                wr_word;
    logic [INDEX_BITS-1:0] rd_idx;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_en         = 1'b0;
        wr_idx        = fill_addr_q[INDEX_BITS-1:0];
        wr_word.valid = 1'b1;
        wr_word.tag   = fill_addr_q[ADDR_BITS-1:INDEX_BITS];
        wr_word.data  = fill_data_q;
        if (state_q == ST_FLUSH) begin
            wr_en   = 1'b1;
            wr_idx  = sweep_q;
            wr_word = '0;
        end else if (fill_valid_q) begin
            wr_en = 1'b1;
        end
    end

    assign rd_idx = req_addr_in[INDEX_BITS-1:0];

    // ------------------------------------------------------------------
    // Tag/data RAM with registered, write-first read
    // ------------------------------------------------------------------
    entry_t mem [ENTRIES];
    entry_t rd_q;

    // NOTE: the array has no reset; valid bits are cleared by the FLUSH sweep instead.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_word;
        end
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_q <= wr_word;
        end else begin
            rd_q <= mem[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Lookup pipeline: S0 request, S1 read result, S2 compare, then outputs
    // ------------------------------------------------------------------
    logic                 s0_valid_q, s0_force_q, s0_count_q;
    logic [ADDR_BITS-1:0] s0_addr_q;
    logic [ID_BITS-1:0]   s0_id_q;

    logic                 s1_valid_q, s1_force_q, s1_count_q;
    logic [ADDR_BITS-1:0] s1_addr_q;
    logic [ID_BITS-1:0]   s1_id_q;
    entry_t               s1_entry_q;

    logic                 s2_valid_q, s2_hit_q, s2_count_q;
    logic [ADDR_BITS-1:0] s2_addr_q;
    logic [ID_BITS-1:0]   s2_id_q;
    logic [DATA_BITS-1:0] s2_data_q;

    logic                 rsp_valid_q, miss_valid_q;
    logic [ID_BITS-1:0]   rsp_id_q, miss_id_q;
    logic [DATA_BITS-1:0] rsp_data_q;
    logic [ADDR_BITS-1:0] miss_addr_q;
    logic [31:0]          hit_cnt_q, miss_cnt_q;

    logic                 s2_hit_d;
    logic                 count_en;
    logic [31:0]          hit_cnt_d, miss_cnt_d;

    always_comb begin
        s2_hit_d = s1_valid_q && !s1_force_q && s1_entry_q.valid &&
                   (s1_entry_q.tag == s1_addr_q[ADDR_BITS-1:INDEX_BITS]);
    end

    // Bypass-mode requests carry count=0, and counting also freezes while disabled.
    always_comb begin
        count_en   = s2_valid_q && s2_count_q && enabled_in;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (count_en && s2_hit_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (count_en && !s2_hit_q && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst_in) begin
            s0_valid_q   <= 1'b0;
            s0_force_q   <= 1'b0;
            s0_count_q   <= 1'b0;
            s0_addr_q    <= '0;
            s0_id_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_force_q   <= 1'b0;
            s1_count_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_id_q      <= '0;
            s1_entry_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_hit_q     <= 1'b0;
            s2_count_q   <= 1'b0;
            s2_addr_q    <= '0;
            s2_id_q      <= '0;
            s2_data_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            miss_valid_q <= 1'b0;
            miss_addr_q  <= '0;
            miss_id_q    <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            s0_valid_q <= req_valid_in;
            s0_force_q <= (state_q == ST_FLUSH) || !enabled_in;
            s0_count_q <= enabled_in;
            s0_addr_q  <= req_addr_in;
            s0_id_q    <= req_id_in;

            s1_valid_q <= s0_valid_q;
            s1_force_q <= s0_force_q;
            s1_count_q <= s0_count_q;
            s1_addr_q  <= s0_addr_q;
            s1_id_q    <= s0_id_q;
            s1_entry_q <= rd_q;

            s2_valid_q <= s1_valid_q;
            s2_hit_q   <= s2_hit_d;
            s2_count_q <= s1_count_q;
            s2_addr_q  <= s1_addr_q;
            s2_id_q    <= s1_id_q;
            s2_data_q  <= s1_entry_q.data;

            rsp_valid_q  <= s2_valid_q && s2_hit_q;
            miss_valid_q <= s2_valid_q && !s2_hit_q;
            if (s2_valid_q && s2_hit_q) begin
                rsp_id_q   <= s2_id_q;
                rsp_data_q <= s2_data_q;
            end
            if (s2_valid_q && !s2_hit_q) begin
                miss_addr_q <= s2_addr_q;
                miss_id_q   <= s2_id_q;
            end

            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign rsp_valid_out  = rsp_valid_q;
    assign rsp_id_out     = rsp_id_q;
    assign rsp_data_out   = {LANES{rsp_data_q}};
    assign miss_valid_out = miss_valid_q;
    assign miss_addr_out  = miss_addr_q;
    assign miss_id_out    = miss_id_q;
    assign busy_out       = busy_q;
    assign flush_done_out = done_q;
    assign hit_count_out  = hit_cnt_q;
    assign miss_count_out = miss_cnt_q;

endmodule

// File: tb/tb_cu_vertex_cache_assoc_module.sv
// Directed bench for cu_vertex_cache_assoc_module with ENTRIES=4; expected values are hand-derived.
module tb_cu_vertex_cache_assoc_module;

    logic         clock = 1'b0;
    logic         rst_in = 1'b1;
    logic         enabled_in = 1'b1;
    logic         flush_in = 1'b0;
    logic         req_valid_in = 1'b0;
    logic [31:0]  req_addr_in = '0;
    logic [7:0]   req_id_in = '0;
    logic         fill_valid_in = 1'b0;
    logic [31:0]  fill_addr_in = '0;
    logic [31:0]  fill_data_in = '0;
    logic         rsp_valid_out;
    logic [7:0]   rsp_id_out;
    logic [511:0] rsp_data_out;
    logic         miss_valid_out;
    logic [31:0]  miss_addr_out;
    logic [7:0]   miss_id_out;
    logic         busy_out;
    logic         flush_done_out;
    logic [31:0]  hit_count_out;
    logic [31:0]  miss_count_out;

    cu_vertex_cache_assoc_module #(
        .ENTRIES(4), .ADDR_BITS(32), .DATA_BITS(32), .ID_BITS(8), .LANES(16)
    ) dut (
        .clock(clock), .rst_in(rst_in), .enabled_in(enabled_in), .flush_in(flush_in),
        .req_valid_in(req_valid_in), .req_addr_in(req_addr_in), .req_id_in(req_id_in),
        .fill_valid_in(fill_valid_in), .fill_addr_in(fill_addr_in), .fill_data_in(fill_data_in),
        .rsp_valid_out(rsp_valid_out), .rsp_id_out(rsp_id_out), .rsp_data_out(rsp_data_out),
        .miss_valid_out(miss_valid_out), .miss_addr_out(miss_addr_out), .miss_id_out(miss_id_out),
        .busy_out(busy_out), .flush_done_out(flush_done_out),
        .hit_count_out(hit_count_out), .miss_count_out(miss_count_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         hit;
        logic [7:0]   id;
        logic [31:0]  addr;
        logic [511:0] data;
        int           at_edge;
    } out_t;

    out_t out_q[$];
    int   sent_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Output monitor: records every response/miss with the edge it appeared after.
    always @(posedge clock) begin
        out_t o;
        cyc++;
        #1;
        if (rsp_valid_out || miss_valid_out) begin
            check("onehot", 512'(rsp_valid_out & miss_valid_out), 512'd0);
            o.hit     = rsp_valid_out;
            o.id      = rsp_valid_out ? rsp_id_out : miss_id_out;
            o.addr    = miss_addr_out;
            o.data    = rsp_data_out;
            o.at_edge = cyc;
            out_q.push_back(o);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [31:0] addr, input logic [7:0] id);
        req_valid_in = 1'b1;
        req_addr_in  = addr;
        req_id_in    = id;
        sent_q.push_back(cyc + 1);
        @(negedge clock);
        req_valid_in = 1'b0;
    endtask

    task automatic fill(input logic [31:0] addr, input logic [31:0] data);
        fill_valid_in = 1'b1;
        fill_addr_in  = addr;
        fill_data_in  = data;
        @(negedge clock);
        fill_valid_in = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic exp_hit, input logic [7:0] exp_id,
                              input logic [31:0] exp_val);
        out_t o;
        int   se;
        int   waited = 0;
        while (out_q.size() == 0 && waited < 12) begin
            @(negedge clock);
            waited++;
        end
        if (out_q.size() == 0) begin
            check({tag, "_timeout"}, 512'd0, 512'd1);
            if (sent_q.size() > 0) void'(sent_q.pop_front());
            return;
        end
        o  = out_q.pop_front();
        se = (sent_q.size() > 0) ? sent_q.pop_front() : -100;
        check({tag, "_hit"}, 512'(o.hit), 512'(exp_hit));
        check({tag, "_id"}, 512'(o.id), 512'(exp_id));
        if (exp_hit) check({tag, "_data"}, o.data, {16{exp_val}});
        else         check({tag, "_addr"}, 512'(o.addr), 512'(exp_val));
        check({tag, "_lat"}, 512'(o.at_edge - se), 512'd3);
    endtask

    initial begin
        int busy_n;
        int done_n;

        // Reset values and post-reset sweep
        idle(3);
        check("rst_rsp_valid", 512'(rsp_valid_out), 512'd0);
        check("rst_miss_valid", 512'(miss_valid_out), 512'd0);
        check("rst_rsp_data", rsp_data_out, 512'd0);
        check("rst_miss_addr", 512'(miss_addr_out), 512'd0);
        check("rst_hit_cnt", 512'(hit_count_out), 512'd0);
        check("rst_miss_cnt", 512'(miss_count_out), 512'd0);
        check("rst_busy", 512'(busy_out), 512'd1);
        rst_in = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy_out) busy_n++;
            if (flush_done_out) done_n++;
            @(negedge clock);
        end
        check("sweep_busy_cycles", 512'(busy_n), 512'd4);
        check("sweep_done_pulses", 512'(done_n), 512'd1);

        send(32'd5, 8'd1);
        expect_out("first_miss", 1'b0, 8'd1, 32'd5);
        check("first_miss_cnt", 512'(miss_count_out), 512'd1);

        // Fill then hit on the next cycle (write-first bypass)
        fill(32'd6, 32'hDEAD_BEEF);
        send(32'd6, 8'd3);
        expect_out("fill_hit", 1'b1, 8'd3, 32'hDEAD_BEEF);
        check("fill_hit_cnt", 512'(hit_count_out), 512'd1);

        // Conflict eviction: 2 and 6 share index 2
        fill(32'd2, 32'h22);
        fill(32'd6, 32'h66);
        send(32'd2, 8'd4);
        send(32'd6, 8'd5);
        expect_out("evict_miss", 1'b0, 8'd4, 32'd2);
        expect_out("evict_hit", 1'b1, 8'd5, 32'h66);

        // Fill and request to the same address on the same edge
        fill_valid_in = 1'b1;
        fill_addr_in  = 32'd9;
        fill_data_in  = 32'h99;
        send(32'd9, 8'd6);
        fill_valid_in = 1'b0;
        send(32'd9, 8'd7);
        expect_out("same_edge_miss", 1'b0, 8'd6, 32'd9);
        expect_out("same_edge_next_hit", 1'b1, 8'd7, 32'h99);
        idle(2);
        check("cnt_hits_a", 512'(hit_count_out), 512'd3);
        check("cnt_miss_a", 512'(miss_count_out), 512'd3);

        // Back-to-back stream alternating cached (6) and uncached (3)
        for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 32'd6 : 32'd3, 8'(i));
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) expect_out($sformatf("stream%0d", i), 1'b1, 8'(i), 32'h66);
            else            expect_out($sformatf("stream%0d", i), 1'b0, 8'(i), 32'd3);
        end
        idle(2);
        check("cnt_hits_b", 512'(hit_count_out), 512'd11);
        check("cnt_miss_b", 512'(miss_count_out), 512'd11);

        // Flush mid-stream
        fill(32'd1, 32'h11);
        flush_in = 1'b1;
        send(32'd1, 8'd21);
        flush_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flush_busy%0d", i), 512'(busy_out), 512'd1);
            send(32'd1, 8'(22 + i));
        end
        check("flush_busy_end", 512'(busy_out), 512'd0);
        check("flush_done_pulse", 512'(flush_done_out), 512'd1);
        send(32'd1, 8'd26);
        fill(32'd1, 32'h12);
        send(32'd1, 8'd27);
        expect_out("flush_old_hit", 1'b1, 8'd21, 32'h11);
        for (int i = 0; i < 4; i++) expect_out($sformatf("flush_miss%0d", i), 1'b0, 8'(22 + i), 32'd1);
        expect_out("post_flush_miss", 1'b0, 8'd26, 32'd1);
        expect_out("refill_hit", 1'b1, 8'd27, 32'h12);
        idle(2);
        check("cnt_hits_c", 512'(hit_count_out), 512'd13);
        check("cnt_miss_c", 512'(miss_count_out), 512'd16);

        // Bypass mode: fill dropped, request forced to miss, counters frozen
        enabled_in = 1'b0;
        fill(32'd2, 32'hAB);
        send(32'd2, 8'd30);
        expect_out("bypass_miss", 1'b0, 8'd30, 32'd2);
        idle(2);
        check("bypass_hits", 512'(hit_count_out), 512'd13);
        check("bypass_miss_cnt", 512'(miss_count_out), 512'd16);
        enabled_in = 1'b1;
        send(32'd2, 8'd31);
        expect_out("dropped_fill_miss", 1'b0, 8'd31, 32'd2);
        idle(2);
        check("cnt_miss_d", 512'(miss_count_out), 512'd17);

        // Reset with a request in flight: no output, counters cleared, sweep restarts
        req_valid_in = 1'b1;
        req_addr_in  = 32'd6;
        req_id_in    = 8'd40;
        @(negedge clock);
        req_valid_in = 1'b0;
        rst_in = 1'b1;
        @(negedge clock);
        rst_in = 1'b0;
        check("midrst_busy", 512'(busy_out), 512'd1);
        idle(7);
        check("midrst_no_output", 512'(out_q.size()), 512'd0);
        check("midrst_hits", 512'(hit_count_out), 512'd0);
        check("midrst_miss", 512'(miss_count_out), 512'd0);
        check("midrst_idle", 512'(busy_out), 512'd0);

        // Hit counter saturation
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        @(negedge clock);
        release dut.hit_cnt_q;
        fill(32'd6, 32'h77);
        send(32'd6, 8'd50);
        expect_out("sat_hit", 1'b1, 8'd50, 32'h77);
        idle(2);
        check("sat_hit_cnt", 512'(hit_count_out), 512'hFFFF_FFFF);
        check("sat_miss_cnt", 512'(miss_count_out), 512'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
